// File: rtl/sr_latch_driver_if.sv
// rtl/sr_latch_driver_if.sv - command and status bundle for the SR latch driver
//
// Purpose: groups the command handshake and the per-command result signals.
// Signals:
//   cmd_valid  command request
//   cmd_op     00 SET, 01 RESET, 10 HOLD, 11 FORBID
//   cmd_ready  driver is idle and will accept cmd_valid on the next edge
//   done       one-cycle pulse at the end of each command
//   pass       result of the last command, held until the next done
//   err_cnt    saturating count of failed commands
//   busy       a command is in progress
// Modports: master drives commands, slave is the driver.

interface sr_latch_driver_if;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic       cmd_ready;
  logic       done;
  logic       pass;
  logic [7:0] err_cnt;
  logic       busy;

  modport master (
    output cmd_valid,
    output cmd_op,
    input  cmd_ready,
    input  done,
    input  pass,
    input  err_cnt,
    input  busy
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    output cmd_ready,
    output done,
    output pass,
    output err_cnt,
    output busy
  );
endinterface

// File: rtl/sr_latch_driver.sv
// rtl/sr_latch_driver.sv - pulses S/R of an external NOR latch and verifies the readback
//
// Purpose: drives S or R of a NOR latch for PULSE_CYC cycles per command, then
// checks the synchronized Q/Qn readback against the expected value for up to
// SETTLE_MAX cycles, reporting pass/fail and counting failures.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          command/status bundle (slave side)
//   s_out, r_out registered drives to the latch S and R inputs
//   q_in, qn_in  latch readback, asynchronous to clk

module sr_latch_driver #(
  parameter int PULSE_CYC  = 4,
  parameter int SETTLE_MAX = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  sr_latch_driver_if.slave   bus,
  output logic               s_out,
  output logic               r_out,
  input  logic               q_in,
  input  logic               qn_in
);

  typedef enum logic [1:0] {IDLE, PULSE, SETTLE, DONE} state_t;

  localparam logic [1:0] OP_SET    = 2'd0;
  localparam logic [1:0] OP_RESET  = 2'd1;
  localparam logic [1:0] OP_HOLD   = 2'd2;
  localparam logic [1:0] OP_FORBID = 2'd3;

  localparam logic [7:0] PULSE_LAST  = 8'(PULSE_CYC - 1);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_MAX - 1);

  state_t     state, state_nxt;
  logic [1:0] op_r, op_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       match_r, match_nxt;
  logic       s_nxt, r_nxt;

  logic [1:0] q_sync, qn_sync;
  logic       q_s, qn_s;

  logic       ready_en;
  logic       cmd_ready_w;
  logic       accept;
  logic       exp_match;

  logic       done_r, pass_r;
  logic [7:0] err_r;
  logic       last_valid, last_q;

  assign q_s  = q_sync[1];
  assign qn_s = qn_sync[1];

  // ready_en keeps cmd_ready low while reset is asserted and for the first
  // edge after release, even though the state register already reads IDLE.
  assign cmd_ready_w = (state == IDLE) && ready_en;
  assign accept      = bus.cmd_valid && cmd_ready_w;

  assign bus.cmd_ready = cmd_ready_w;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_r;
  assign bus.pass      = pass_r;
  assign bus.err_cnt   = err_r;

  always_comb begin
    exp_match = 1'b0;
    case (op_r)
      OP_SET:    exp_match = q_s && !qn_s;
      OP_RESET:  exp_match = !q_s && qn_s;
      OP_FORBID: exp_match = !q_s && !qn_s;
      default: begin
        // HOLD without a trusted last value can only check complementarity.
        if (last_valid) exp_match = (q_s == last_q) && (qn_s == !last_q);
        else            exp_match = (qn_s != q_s);
      end
    endcase
  end

  always_comb begin
    state_nxt = state;
    op_nxt    = op_r;
    cnt_nxt   = cnt;
    match_nxt = match_r;
    case (state)
      IDLE: begin
        if (accept) begin
          op_nxt    = bus.cmd_op;
          cnt_nxt   = 8'd0;
          state_nxt = (bus.cmd_op == OP_HOLD) ? SETTLE : PULSE;
        end
      end
      PULSE: begin
        if (cnt == PULSE_LAST) begin
          state_nxt = SETTLE;
          cnt_nxt   = 8'd0;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      SETTLE: begin
        if (exp_match) begin
          state_nxt = DONE;
          match_nxt = 1'b1;
        end else if (cnt == SETTLE_LAST) begin
          state_nxt = DONE;
          match_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 8'd0;
      end
    endcase

    // Drives are decoded from the next state so they are registered in step
    // with the state change; FORBID keeps both high through SETTLE.
    s_nxt = ((state_nxt == PULSE) && ((op_nxt == OP_SET) || (op_nxt == OP_FORBID))) ||
            ((state_nxt == SETTLE) && (op_nxt == OP_FORBID));
    r_nxt = ((state_nxt == PULSE) && ((op_nxt == OP_RESET) || (op_nxt == OP_FORBID))) ||
            ((state_nxt == SETTLE) && (op_nxt == OP_FORBID));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_r     <= OP_SET;
      cnt      <= 8'd0;
      match_r  <= 1'b0;
      s_out    <= 1'b0;
      r_out    <= 1'b0;
      q_sync   <= 2'b00;
      qn_sync  <= 2'b00;
      ready_en <= 1'b0;
    end else begin
      state    <= state_nxt;
      op_r     <= op_nxt;
      cnt      <= cnt_nxt;
      match_r  <= match_nxt;
      s_out    <= s_nxt;
      r_out    <= r_nxt;
      q_sync   <= {q_sync[0], q_in};
      qn_sync  <= {qn_sync[0], qn_in};
      ready_en <= 1'b1;
    end
  end

  // Results are published on the edge that leaves DONE, so done/pass/err_cnt
  // all change together and done is high for exactly one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_r     <= 1'b0;
      pass_r     <= 1'b0;
      err_r      <= 8'd0;
      last_valid <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      done_r <= (state == DONE);
      if (state == DONE) begin
        pass_r <= match_r;
        if (!match_r) begin
          if (err_r != 8'hFF) err_r <= err_r + 8'd1;
          last_valid <= 1'b0;
        end else if ((op_r == OP_SET) || (op_r == OP_RESET)) begin
          last_valid <= 1'b1;
          last_q     <= (op_r == OP_SET);
        end else if (op_r == OP_FORBID) begin
          last_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/sr_latch_driver.md
SR_LATCH_DRIVER -- requirements
Module: sr_latch_driver

Interface
REQ-001 Parameter PULSE_CYC, default 4: number of cycles S or R is driven per command; legal range 2..15.
REQ-002 Parameter SETTLE_MAX, default 15: maximum SETTLE-state cycles before a timeout failure; legal range 1..255.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 cmd_valid  in  1  command request.
REQ-006 cmd_op  in  2  operation code: 00 SET, 01 RESET, 10 HOLD (readback only), 11 FORBID (S and R both high).
REQ-007 cmd_ready  out  1  high only in IDLE.
REQ-008 s_out  out  1  registered set drive to the NOR latch S input.
REQ-009 r_out  out  1  registered reset drive to the NOR latch R input.
REQ-010 q_in  in  1  latch Q readback; asynchronous to clk.
REQ-011 qn_in  in  1  latch Qn readback; asynchronous to clk.
REQ-012 done  out  1  one-cycle pulse marking the end of each command.
REQ-013 pass  out  1  result of the last command; valid when done=1 and held until the next done.
REQ-014 err_cnt  out  8  saturating count of failed commands.
REQ-015 busy  out  1  high whenever the state is not IDLE.

Function
REQ-016 q_in and qn_in SHALL each pass through a 2-flop synchronizer; only the synchronized values q_s and qn_s are used.
REQ-017 The FSM SHALL have the states IDLE, PULSE, SETTLE and DONE, with a one-hot or binary encoding.
REQ-018 A command SHALL be accepted on a clk edge with cmd_valid=1 and cmd_ready=1; cmd_op is latched at that edge.
REQ-019 cmd_valid while busy=1 SHALL be ignored, and nothing is queued.
REQ-020 Transitions: IDLE->PULSE on acceptance of SET, RESET or FORBID; IDLE->SETTLE on acceptance of HOLD.
REQ-021 PULSE SHALL last exactly PULSE_CYC cycles and then go to SETTLE.
REQ-022 During PULSE: s_out=1 for SET and FORBID; r_out=1 for RESET and FORBID; both outputs are 0 otherwise.
REQ-023 For FORBID, s_out and r_out SHALL stay high through SETTLE and drop on entry to DONE.
REQ-024 s_out and r_out SHALL never both be 1 except during FORBID.
REQ-025 Expected values: SET q_s=1, qn_s=0; RESET q_s=0, qn_s=1; FORBID q_s=0, qn_s=0.
REQ-026 HOLD with last_valid=1 expects q_s=last_q and qn_s=~last_q; HOLD with last_valid=0 expects only qn_s=~q_s.
REQ-027 SETTLE SHALL compare q_s and qn_s with the expected values every cycle and go to DONE with pass=1 on the first match.
REQ-028 SETTLE SHALL go to DONE with pass=0 after SETTLE_MAX cycles without a match, using an 8-bit cycle counter.
REQ-029 In DONE, done SHALL be 1 for one cycle; the FSM then returns to IDLE.
REQ-030 On a failed command, err_cnt SHALL increment, saturating at 255.
REQ-031 On a passing SET or RESET, last_q SHALL be set to the expected q and last_valid to 1.
REQ-032 Any FORBID or any failure SHALL clear last_valid to 0.
REQ-033 With a zero-delay latch, the latency from acceptance to done SHALL be PULSE_CYC+2 cycles for SET, RESET and FORBID.
REQ-034 With a stable latch, the latency from acceptance to done SHALL be 2 cycles for HOLD.

Reset
REQ-035 While rst_n=0, all of the following SHALL hold immediately (asynchronously): state=IDLE, s_out=0, r_out=0, done=0, pass=0, err_cnt=0, last_valid=0, last_q=0, counters=0, synchronizers=0, busy=0.
REQ-036 cmd_ready SHALL be 1 only after rst_n deasserts.
REQ-037 Reset mid-PULSE SHALL release s_out and r_out within the same cycle; the aborted command produces no done.

Verification
REQ-038 SET with a zero-delay NOR-latch model: s_out high for 4 cycles, done on cycle 6 after acceptance, pass=1, err_cnt=0.
REQ-039 RESET after SET, then HOLD: RESET gives pass=1; HOLD gives done 2 cycles after acceptance, pass=1, q_in=0.
REQ-040 Stuck-at-0 q_in on SET: done on cycle 4+15+1 after acceptance, pass=0, err_cnt=1, last_valid=0.
REQ-041 FORBID: s_out=r_out=1 for 4+ cycles, model drives Q=Qn=0, pass=1; following HOLD checks complementarity only.
REQ-042 Back-to-back cmd_valid held high through 300 failing commands: err_cnt saturates at 255; valid while busy is never accepted.
REQ-043 rst_n pulled low on cycle 2 of PULSE: s_out=0 in the same cycle, no done, err_cnt=0, cmd_ready=1 one cycle after release.
